// File: rtl/dac7611_serial_rx.sv
// Oversampling receiver for the DAC7611 3-wire load interface. It rebuilds the
// code the DAC would latch and flags completed frames, clears and bad frames.
//
// state | meaning
// IDLE  | bus quiet, waiting for the first CLK rise of a frame
// SHIFT | collecting SDI bits, one per CLK rise
// LOAD  | LD seen low, waiting for LD to return high
module dac7611_serial_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        dac_signals_in,
    output logic [DATA_W-1:0] dac_code,
    output logic              code_valid,
    output logic              frame_error,
    output logic              clear_pulse,
    output logic [CNT_W-1:0]  frame_count,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    logic [3:0]        sync_q [SYNC_STAGES];
    logic [3:0]        sync_d [SYNC_STAGES];
    logic [2:0]        prev_q;
    logic [3:0]        bus_s;
    logic              clk_rise, ld_fall, clr_fall, clr_low;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] dac_code_q, dac_code_d;
    logic              code_valid_q, code_valid_d;
    logic              frame_error_q, frame_error_d;
    logic              clear_pulse_q, clear_pulse_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;

    // Synchronizer chain: each stage takes the previous one.
    always_comb begin
        sync_d[0] = dac_signals_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign bus_s    = sync_q[SYNC_STAGES-1];
    // prev_q keeps only {CLK, LD, CLR}; SDI needs no edge detection.
    assign clk_rise = bus_s[3] & ~prev_q[2];
    assign ld_fall  = ~bus_s[1] & prev_q[1];
    assign clr_fall = ~bus_s[0] & prev_q[0];
    assign clr_low  = ~bus_s[0];

    // Synchronizer and edge-detect registers, preset to the idle bus pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'b1011;
            end
            prev_q <= 3'b111;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q <= {bus_s[3], bus_s[1], bus_s[0]};
        end
    end

    // Frame FSM: CLR low overrides everything, then LD fall, then CLK rise.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        dac_code_d    = dac_code_q;
        code_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        clear_pulse_d = clr_fall;
        frame_count_d = frame_count_q;

        if (clr_low) begin
            dac_code_d = '0;
            shreg_d    = '0;
            bit_cnt_d  = '0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_fall) begin
                        // Zero-bit frame; a simultaneous rise is an error too.
                        frame_error_d = 1'b1;
                        state_d       = LOAD;
                    end else if (clk_rise && bus_s[1]) begin
                        shreg_d   = {shreg_q[DATA_W-2:0], bus_s[2]};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (ld_fall) begin
                        // Load judged on pre-shift state; a coincident rise
                        // counts as a violation of the LOAD phase.
                        if (bit_cnt_q == BW'(DATA_W)) begin
                            dac_code_d    = shreg_q;
                            code_valid_d  = 1'b1;
                            frame_count_d = frame_count_q + CNT_W'(1);
                        end else begin
                            frame_error_d = 1'b1;
                        end
                        if (clk_rise) begin
                            frame_error_d = 1'b1;
                        end
                        state_d = LOAD;
                    end else if (clk_rise) begin
                        shreg_d = {shreg_q[DATA_W-2:0], bus_s[2]};
                        if (bit_cnt_q != '1) begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (clk_rise) begin
                        frame_error_d = 1'b1;
                    end
                    if (bus_s[1]) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Datapath and FSM state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            dac_code_q    <= '0;
            code_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            clear_pulse_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            dac_code_q    <= dac_code_d;
            code_valid_q  <= code_valid_d;
            frame_error_q <= frame_error_d;
            clear_pulse_q <= clear_pulse_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign dac_code    = dac_code_q;
    assign code_valid  = code_valid_q;
    assign frame_error = frame_error_q;
    assign clear_pulse = clear_pulse_q;
    assign frame_count = frame_count_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/dac7611_serial_rx.md
Name: dac7611_serial_rx

Overview:
Receiver/monitor for the DAC7611 3-wire serial load interface (CLK, SDI, LD, CLR) that our DAC driver emits on the 4-bit dac_signals bus. It oversamples the bus with the fabric clock, reconstructs the 12-bit code the DAC would latch, and reports frame completion and protocol errors. It is used for on-board loopback self-test of the DAC path and as a checker in simulation.

Parameters:
DATA_W, 12, bits per frame / width of reconstructed code
SYNC_STAGES, 2, synchronizer flops per input bit (min 2)
CNT_W, 16, width of frame_count

Ports:
clk  input  1  fabric clock; DAC CLK half-period is at least 2 clk periods
reset  input  1  synchronous, active-high reset
dac_signals_in  input  4  [3]=CLK, [2]=SDI, [1]=LD (active low), [0]=CLR (active low); asynchronous to clk
dac_code  output  DATA_W  last successfully loaded code, MSB first on wire
code_valid  output  1  one-cycle pulse when dac_code updates from a good frame
frame_error  output  1  one-cycle pulse on a malformed frame
clear_pulse  output  1  one-cycle pulse on CLR falling edge
frame_count  output  CNT_W  count of good frames, wraps at 2^CNT_W
busy  output  1  high in SHIFT or LOAD

Behaviour:
- Reset (clk edge with reset=1): sync flops and their delayed copies = idle pattern 4'b1011 (CLK=1, SDI=0, LD=1, CLR=1). shreg=0, bit_cnt=0, state=IDLE, dac_code=0, code_valid=0, frame_error=0, clear_pulse=0, frame_count=0.
- Each input bit passes through SYNC_STAGES flops. A registered copy of the synced value gives edge detection: clk_rise = synced CLK 0->1, ld_fall = synced LD 1->0, clr_fall = synced CLR 1->0.
- On clk_rise, shift in SDI: shreg <= {shreg[DATA_W-2:0], SDI_sync}, taken from the same synced cycle. The driver holds SDI stable across 4 clk around the rise.
- bit_cnt: width clog2(DATA_W+4); increments per accepted clk_rise and saturates at all-ones.
- FSM states:
  - IDLE: clk_rise with LD=1 goes to SHIFT and shifts the first bit. ld_fall goes to LOAD with frame_error (0-bit frame).
  - SHIFT: clk_rise shifts. ld_fall: if bit_cnt==DATA_W, dac_code<=shreg, code_valid=1 and frame_count+1; otherwise frame_error=1 and dac_code is held. Either way go to LOAD.
  - LOAD: wait for synced LD=1, then bit_cnt<=0 and go to IDLE. A clk_rise in LOAD gives one frame_error pulse per rise and no shift.
- More than DATA_W bits: shreg keeps the last DATA_W bits, but the LD is still an error and no load happens.
- CLR: while synced CLR=0, dac_code=0, shreg=0, bit_cnt=0, state=IDLE, and all clk_rise/ld_fall are ignored. clear_pulse fires on clr_fall only. frame_count is unaffected.
- Priority within one cycle: reset > CLR low > ld_fall > clk_rise. ld_fall and clk_rise in the same cycle: the load is evaluated on the pre-shift bit_cnt/shreg, then the rise is treated as a LOAD-state violation.
- Latency: code_valid and dac_code become visible SYNC_STAGES+1 clk edges after the first edge that samples LD low. clear_pulse has the same latency.
- code_valid, frame_error and clear_pulse are never high for more than one cycle per event.
- busy = (state != IDLE).

Test Plan:
- Reset held for 3 cycles with a random bus → dac_code=0, frame_count=0, no pulses, busy=0; an idle bus afterwards produces no pulses.
- Driver-style frame 12'h555 (CLK half-period 2 clk, LD low 2 clk) → one code_valid exactly 3 edges after LD is sampled low; dac_code=12'h555, frame_count=1.
- Back-to-back frames 12'hA5C then 12'h3FF → two code_valid pulses, dac_code=12'hA5C then 12'h3FF, frame_count=2.
- 11-bit frame then LD, followed by a 14-bit frame then LD → two frame_error pulses, no code_valid, dac_code holds the prior value 12'h3FF.
- CLR low for 2 clk after 6 bits of a frame → clear_pulse, dac_code=0, busy=0; a following 12'h123 frame loads 12'h123 correctly. CLR and LD falling together → clear wins, no code_valid.
- reset asserted mid-frame after 5 bits, then a full 12'hFFF frame → frame_count=1, dac_code=12'hFFF; no error from the aborted frame.
